cursor_pair_adder: RTL and testbench

Synchronous, parametrised cursor-and-confirm move engine for the two-row digit game. It tracks a cursor over two rows of up to N_MAX slots and detects rising edges on the debounced buttons internally. A legal source/target pick produces (src + dst) mod MOD, plus the slot indices for the game-state writer. It sits between the button debouncers and the board-state register file, and adds move legality checks, a reject pulse and a held-button-safe reset.

---
 rtl/cursor_pair_adder.sv | 164 ++++++++++++++++
 tb/tb_cursor_pair_adder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_pair_adder.sv
// Cursor-and-confirm move engine for the two-row digit game: button edge detect,
// cursor navigation, source/target legality checks and (src + dst) mod MOD result.
module cursor_pair_adder #(
  parameter int N_MAX = 5,
  parameter int VAL_W = 4,
  parameter int MOD   = 10,
  parameter int IDX_W = $clog2(2*N_MAX),
  parameter int NUM_W = $clog2(N_MAX+1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     player,
  input  logic [NUM_W-1:0]         num,
  input  logic [2*N_MAX*VAL_W-1:0] status,
  input  logic                     btn_up,
  input  logic                     btn_down,
  input  logic                     btn_left,
  input  logic                     btn_right,
  input  logic                     btn_ok,
  output logic [IDX_W-1:0]         cursor,
  output logic                     holding,
  output logic [IDX_W-1:0]         src_index,
  output logic [IDX_W-1:0]         dst_index,
  output logic [VAL_W-1:0]         result,
  output logic                     result_valid,
  output logic                     draw_p1,
  output logic                     draw_p2,
  output logic                     reject
);

  typedef enum logic {S_SRC, S_DST} state_t;

  localparam logic [IDX_W-1:0] NM    = IDX_W'(N_MAX);
  localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);
  localparam logic [VAL_W:0]   MOD_W = (VAL_W+1)'(MOD);

  state_t            state_q;
  logic [4:0]        prev_q;
  logic [IDX_W-1:0]  cursor_q, src_idx_q, src_index_q, dst_index_q;
  logic [VAL_W-1:0]  src_val_q, result_q;
  logic              holding_q, result_valid_q, draw_p1_q, draw_p2_q, reject_q;

  // button order in the vector: {ok, up, down, left, right}
  logic [4:0]        lvl, rise;
  logic [VAL_W-1:0]  slots [2*N_MAX];
  logic [IDX_W-1:0]  n_eff, col, last0, last1;
  logic [IDX_W-1:0]  clamp_idx, toggle_idx, right_idx, left_idx;
  logic              row, clamp_hit, own_row, val_ok, val_zero;
  logic [VAL_W-1:0]  cur_val, res_val;
  logic [VAL_W:0]    sum;

  assign lvl  = {btn_ok, btn_up, btn_down, btn_left, btn_right};
  assign rise = lvl & ~prev_q;

  always_comb begin
    for (int unsigned i = 0; i < 2*N_MAX; i++) begin
      slots[i] = status[i*VAL_W +: VAL_W];
    end
  end

  always_comb begin
    if (num == '0)                     n_eff = ONE;
    else if (num > NUM_W'(N_MAX))      n_eff = NM;
    else                               n_eff = IDX_W'(num);
    row        = (cursor_q >= NM);
    col        = row ? (cursor_q - NM) : cursor_q;
    last0      = n_eff - ONE;
    last1      = NM + n_eff - ONE;
    clamp_hit  = (col >= n_eff);
    clamp_idx  = row ? last1 : last0;
    toggle_idx = row ? col : (col + NM);
    // right/left walk row0 col0..n-1 then row1 col0..n-1, wrapping at both ends
    if (cursor_q == last1)      right_idx = '0;
    else if (cursor_q == last0) right_idx = NM;
    else                        right_idx = cursor_q + ONE;
    if (cursor_q == '0)         left_idx = last1;
    else if (cursor_q == NM)    left_idx = last0;
    else                        left_idx = cursor_q - ONE;
    cur_val  = slots[cursor_q];
    own_row  = (row == player);
    val_ok   = ({1'b0, cur_val} < MOD_W);
    val_zero = (cur_val == '0);
    sum      = {1'b0, src_val_q} + {1'b0, cur_val};
    res_val  = (sum >= MOD_W) ? VAL_W'(sum - MOD_W) : VAL_W'(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q         <= lvl;
      state_q        <= S_SRC;
      cursor_q       <= '0;
      holding_q      <= 1'b0;
      src_idx_q      <= '0;
      src_val_q      <= '0;
      src_index_q    <= '0;
      dst_index_q    <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      draw_p1_q      <= 1'b0;
      draw_p2_q      <= 1'b0;
      reject_q       <= 1'b0;
    end else begin
      prev_q         <= lvl;
      result_valid_q <= 1'b0;
      draw_p1_q      <= 1'b0;
      draw_p2_q      <= 1'b0;
      reject_q       <= 1'b0;
      if (clamp_hit) begin
        cursor_q <= clamp_idx;
      end else if (rise[4]) begin
        unique case (state_q)
          S_SRC: begin
            if (own_row && !val_zero && val_ok) begin
              src_idx_q <= cursor_q;
              src_val_q <= cur_val;
              state_q   <= S_DST;
              holding_q <= 1'b1;
            end else begin
              reject_q <= 1'b1;
            end
          end
          S_DST: begin
            if (own_row) begin
              reject_q  <= 1'b1;
              state_q   <= S_SRC;
              cursor_q  <= '0;
              holding_q <= 1'b0;
            end else if (!val_ok) begin
              reject_q <= 1'b1;
            end else begin
              result_q       <= res_val;
              result_valid_q <= 1'b1;
              src_index_q    <= src_idx_q;
              dst_index_q    <= cursor_q;
              draw_p1_q      <= val_zero && !player;
              draw_p2_q      <= val_zero && player;
              state_q        <= S_SRC;
              cursor_q       <= '0;
              holding_q      <= 1'b0;
            end
          end
          default: state_q <= S_SRC;
        endcase
      end else if (rise[3] || rise[2]) begin
        cursor_q <= toggle_idx;
      end else if (rise[1]) begin
        cursor_q <= left_idx;
      end else if (rise[0]) begin
        cursor_q <= right_idx;
      end
    end
  end

  assign cursor       = cursor_q;
  assign holding      = holding_q;
  assign src_index    = src_index_q;
  assign dst_index    = dst_index_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign draw_p1      = draw_p1_q;
  assign draw_p2      = draw_p2_q;
  assign reject       = reject_q;

endmodule

// File: tb/tb_cursor_pair_adder.sv
// Self-checking bench for cursor_pair_adder: directed game scenarios plus random
// stimulus, all compared every cycle against a linear-order behavioural model.
module tb_cursor_pair_adder;
  localparam int N_MAX = 5;
  localparam int VAL_W = 4;
  localparam int MOD   = 10;
  localparam int IDX_W = $clog2(2*N_MAX);
  localparam int NUM_W = $clog2(N_MAX+1);
  localparam int B_RIGHT = 0, B_LEFT = 1, B_DOWN = 2, B_UP = 3, B_OK = 4;

  logic                     clk;
  logic                     rst;
  logic                     player;
  logic [NUM_W-1:0]         num;
  logic [2*N_MAX*VAL_W-1:0] status;
  logic [4:0]               btns;
  logic [IDX_W-1:0]         cursor, src_index, dst_index;
  logic                     holding, result_valid, draw_p1, draw_p2, reject;
  logic [VAL_W-1:0]         result;

  cursor_pair_adder #(.N_MAX(N_MAX), .VAL_W(VAL_W), .MOD(MOD)) dut (
    .clk(clk), .rst(rst), .player(player), .num(num), .status(status),
    .btn_up(btns[B_UP]), .btn_down(btns[B_DOWN]), .btn_left(btns[B_LEFT]),
    .btn_right(btns[B_RIGHT]), .btn_ok(btns[B_OK]),
    .cursor(cursor), .holding(holding), .src_index(src_index), .dst_index(dst_index),
    .result(result), .result_valid(result_valid), .draw_p1(draw_p1), .draw_p2(draw_p2),
    .reject(reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int   e_cursor, e_src_index, e_dst_index, e_result;
  bit   e_hold, e_valid, e_d1, e_d2, e_rej;
  int   m_sidx, m_sval;
  bit [4:0] m_prev;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int slot_val(input int idx);
    return int'(status[idx*VAL_W +: VAL_W]);
  endfunction

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_update();
    bit [4:0] r;
    int n, row, col, v, pos;
    if (rst) begin
      m_prev = btns;
      e_cursor = 0; e_hold = 0; e_src_index = 0; e_dst_index = 0; e_result = 0;
      e_valid = 0; e_d1 = 0; e_d2 = 0; e_rej = 0;
      return;
    end
    r = btns & ~m_prev;
    m_prev = btns;
    e_valid = 0; e_d1 = 0; e_d2 = 0; e_rej = 0;
    n = (num == 0) ? 1 : ((int'(num) > N_MAX) ? N_MAX : int'(num));
    row = e_cursor / N_MAX;
    col = e_cursor % N_MAX;
    if (col >= n) begin
      e_cursor = row*N_MAX + n - 1;
    end else if (r[B_OK]) begin
      v = slot_val(e_cursor);
      if (!e_hold) begin
        if (row == int'(player) && v != 0 && v < MOD) begin
          e_hold = 1; m_sidx = e_cursor; m_sval = v;
        end else e_rej = 1;
      end else if (row == int'(player)) begin
        e_rej = 1; e_hold = 0; e_cursor = 0;
      end else if (v >= MOD) begin
        e_rej = 1;
      end else begin
        e_result = (m_sval + v) % MOD;
        e_valid = 1; e_src_index = m_sidx; e_dst_index = e_cursor;
        e_d1 = (v == 0) && !player;
        e_d2 = (v == 0) && player;
        e_hold = 0; e_cursor = 0;
      end
    end else if (r[B_UP] || r[B_DOWN]) begin
      e_cursor = (1 - row)*N_MAX + col;
    end else if (r[B_LEFT] || r[B_RIGHT]) begin
      pos = row*n + col;
      pos = r[B_LEFT] ? (pos + 2*n - 1) % (2*n) : (pos + 1) % (2*n);
      e_cursor = (pos / n)*N_MAX + (pos % n);
    end
  endtask

  task automatic compare_all();
    chk("cursor",       32'(cursor),       e_cursor);
    chk("holding",      32'(holding),      32'(e_hold));
    chk("src_index",    32'(src_index),    e_src_index);
    chk("dst_index",    32'(dst_index),    e_dst_index);
    chk("result",       32'(result),       e_result);
    chk("result_valid", 32'(result_valid), 32'(e_valid));
    chk("draw_p1",      32'(draw_p1),      32'(e_d1));
    chk("draw_p2",      32'(draw_p2),      32'(e_d2));
    chk("reject",       32'(reject),       32'(e_rej));
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input int b);
    btns[b] = 1'b1; tick();
    btns = '0;      tick();
  endtask

  initial begin
    rst = 1'b1; player = 1'b0; num = NUM_W'(5); status = '0; btns = '0;
    tick(); tick();
    rst = 1'b0; tick();
    chk("lit_reset_cursor", 32'(cursor), 0);
    chk("lit_reset_holding", 32'(holding), 0);

    // cursor walk, num = 5
    for (int i = 0; i < 5; i++) press(B_RIGHT);
    chk("lit_right5", 32'(cursor), 5);
    press(B_LEFT);  chk("lit_left_4", 32'(cursor), 4);
    press(B_UP);    chk("lit_up_9",   32'(cursor), 9);
    press(B_DOWN);  chk("lit_down_4", 32'(cursor), 4);

    // num = 3: clamp then wrap cases
    num = NUM_W'(3); tick();
    chk("lit_clamp_2", 32'(cursor), 2);
    press(B_RIGHT); chk("lit_right2_5", 32'(cursor), 5);
    for (int i = 0; i < 3; i++) press(B_LEFT);
    chk("lit_back_0", 32'(cursor), 0);
    press(B_LEFT);  chk("lit_left0_7", 32'(cursor), 7);
    press(B_RIGHT); chk("lit_right7_0", 32'(cursor), 0);

    // legal move 1 -> 6 : 7 + 8 = 15 -> 5
    num = NUM_W'(5);
    status[1*VAL_W +: VAL_W] = 4'd7;
    status[6*VAL_W +: VAL_W] = 4'd8;
    press(B_RIGHT); press(B_OK);
    chk("lit_holding", 32'(holding), 1);
    for (int i = 0; i < 5; i++) press(B_RIGHT);
    btns[B_OK] = 1'b1; tick();
    chk("lit_mv_valid", 32'(result_valid), 1);
    chk("lit_mv_result", 32'(result), 5);
    chk("lit_mv_src", 32'(src_index), 1);
    chk("lit_mv_dst", 32'(dst_index), 6);
    chk("lit_mv_draw", 32'(draw_p1), 0);
    btns = '0; tick();
    chk("lit_mv_pulse_end", 32'(result_valid), 0);
    chk("lit_mv_hold_result", 32'(result), 5);

    // move 1 -> 8 onto a zero: 7 + 0 = 7, draw for player 0
    press(B_RIGHT); press(B_OK);
    for (int i = 0; i < 7; i++) press(B_RIGHT);
    btns[B_OK] = 1'b1; tick();
    chk("lit_draw_result", 32'(result), 7);
    chk("lit_draw_p1", 32'(draw_p1), 1);
    chk("lit_draw_p2", 32'(draw_p2), 0);
    btns = '0; tick();

    // illegal confirms
    for (int i = 0; i < 5; i++) press(B_RIGHT);
    btns[B_OK] = 1'b1; tick();
    chk("lit_rej_opp_src", 32'(reject), 1);
    chk("lit_rej_opp_hold", 32'(holding), 0);
    btns = '0; tick();
    for (int i = 0; i < 4; i++) press(B_LEFT);
    press(B_OK);
    press(B_RIGHT); press(B_RIGHT);
    btns[B_OK] = 1'b1; tick();
    chk("lit_rej_own_dst", 32'(reject), 1);
    chk("lit_rej_own_cursor", 32'(cursor), 0);
    btns = '0; tick();
    btns[B_OK] = 1'b1; tick();
    chk("lit_rej_zero_src", 32'(reject), 1);
    btns = '0; tick();

    // ok and right together: only the confirm acts
    press(B_RIGHT);
    btns[B_OK] = 1'b1; btns[B_RIGHT] = 1'b1; tick();
    chk("lit_simul_cursor", 32'(cursor), 1);
    chk("lit_simul_hold", 32'(holding), 1);
    btns = '0; tick();

    // reset while holding a source
    rst = 1'b1; tick();
    chk("lit_rst_dst_hold", 32'(holding), 0);
    chk("lit_rst_dst_valid", 32'(result_valid), 0);
    rst = 1'b0; tick();

    // right held across reset
    btns[B_RIGHT] = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; tick(); tick();
    chk("lit_held_rst", 32'(cursor), 0);
    btns = '0; tick();
    chk("lit_held_release", 32'(cursor), 0);

    // random stimulus
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 5; b++) btns[b] = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) num = NUM_W'($urandom_range(0, 7));
      else if ($urandom_range(0, 3) == 0) num = NUM_W'(5);
      if ($urandom_range(0, 19) == 0) player = ~player;
      if ($urandom_range(0, 4) == 0) begin
        for (int s = 0; s < 2*N_MAX; s++) status[s*VAL_W +: VAL_W] = VAL_W'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
